// File: rtl/vec_chunk_server.sv
// Vector buffer in front of an MVProd layer: packs input bytes into chunks, serves them, drains results.
// Optional proto_err output when VCB_PROTOCOL_CHECK_EN is defined.
module vec_chunk_server #(
    parameter int InVecLength  = 8,
    parameter int OutVecLength = 4,
    parameter int WorkingRegs  = 4
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            wr_valid,
    input  logic signed [7:0]               wr_data,
    output logic                            wr_ready,
    output logic                            in_data_ready,
    output logic signed [WorkingRegs*8-1:0] in_data,
    input  logic                            req_chunk_in,
    input  logic                            req_chunk_ptr_rst,
    input  logic                            req_chunk_out,
    input  logic signed [7:0]               write_out_data,
    input  logic                            out_vector_valid,
`ifdef VCB_PROTOCOL_CHECK_EN
    output logic                            proto_err,
`endif
    output logic                            out_valid,
    output logic signed [7:0]               out_data,
    input  logic                            out_ready
);

    localparam int NumChunks = InVecLength / WorkingRegs;
    localparam int ChW = (NumChunks > 1) ? $clog2(NumChunks) : 1;
    localparam int LnW = (WorkingRegs > 1) ? $clog2(WorkingRegs) : 1;
    localparam int DpW = (OutVecLength > 1) ? $clog2(OutVecLength) : 1;
    localparam int OcW = $clog2(OutVecLength + 1);

    localparam logic [ChW-1:0] LastChunk = ChW'(NumChunks - 1);
    localparam logic [LnW-1:0] LastLane  = LnW'(WorkingRegs - 1);
    localparam logic [DpW-1:0] LastDrain = DpW'(OutVecLength - 1);
    localparam logic [OcW-1:0] OutFull   = OcW'(OutVecLength);
    localparam logic [OcW-1:0] OutLast   = OcW'(OutVecLength - 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        SERVE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, nxt;

    logic [7:0]     in_mem  [NumChunks][WorkingRegs];
    logic [7:0]     out_mem [OutVecLength];
    logic [ChW-1:0] wr_chunk;
    logic [LnW-1:0] wr_lane;
    logic [ChW-1:0] rd_ptr;
    logic [OcW-1:0] out_cnt;
    logic [DpW-1:0] drain_ptr;

    logic wr_fire;
    logic last_in;
    logic srv;
    logic out_take;
    logic out_fire;
    logic drain_done;

    assign wr_ready   = (state == FILL);
    assign srv        = (state == SERVE);
    assign wr_fire    = wr_valid && (state == FILL);
    assign last_in    = (wr_chunk == LastChunk) && (wr_lane == LastLane);
    assign out_take   = srv && req_chunk_out && (out_cnt != OutFull);
    assign out_fire   = out_valid && out_ready && (state == DRAIN);
    assign drain_done = out_fire && (drain_ptr == LastDrain);

    always_comb begin
        in_data = '0;
        for (int j = 0; j < WorkingRegs; j++) begin
            in_data[j*8 +: 8] = in_mem[rd_ptr][j];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= FILL;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            FILL:    if (wr_fire && last_in) nxt = SERVE;
            SERVE:   if (out_take && (out_cnt == OutLast)) nxt = DRAIN;
            DRAIN:   if (drain_done) nxt = FILL;
            default: nxt = FILL;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int c = 0; c < NumChunks; c++) begin
                for (int l = 0; l < WorkingRegs; l++) begin
                    in_mem[c][l] <= '0;
                end
            end
            for (int o = 0; o < OutVecLength; o++) begin
                out_mem[o] <= '0;
            end
            wr_chunk      <= '0;
            wr_lane       <= '0;
            rd_ptr        <= '0;
            out_cnt       <= '0;
            drain_ptr     <= '0;
            in_data_ready <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
        end else begin
            if (wr_fire) begin
                in_mem[wr_chunk][wr_lane] <= wr_data;
                if (wr_lane == LastLane) begin
                    wr_lane  <= '0;
                    wr_chunk <= last_in ? '0 : wr_chunk + 1'b1;
                end else begin
                    wr_lane <= wr_lane + 1'b1;
                end
                if (last_in) begin
                    rd_ptr        <= '0;
                    out_cnt       <= '0;
                    in_data_ready <= 1'b1;
                end
            end

            // Rewind wins over advance so the engine can restart a pass cleanly.
            if (srv) begin
                if (req_chunk_in) in_data_ready <= 1'b0;
                if (req_chunk_ptr_rst)
                    rd_ptr <= '0;
                else if (req_chunk_in)
                    rd_ptr <= (rd_ptr == LastChunk) ? '0 : rd_ptr + 1'b1;
            end

            if (out_take) begin
                out_mem[out_cnt[DpW-1:0]] <= write_out_data;
                out_cnt <= out_cnt + 1'b1;
                if (out_cnt == OutLast) drain_ptr <= '0;
            end

            if (state == DRAIN) begin
                if (!out_valid) begin
                    out_valid <= 1'b1;
                    out_data  <= out_mem[drain_ptr];
                end else if (out_ready) begin
                    if (drain_ptr == LastDrain) begin
                        out_valid <= 1'b0;
                        drain_ptr <= '0;
                    end else begin
                        drain_ptr <= drain_ptr + 1'b1;
                        out_data  <= out_mem[drain_ptr + 1'b1];
                    end
                end
            end
        end
    end

`ifdef VCB_PROTOCOL_CHECK_EN
    logic err_now;
    assign err_now = (!srv && (req_chunk_in || req_chunk_ptr_rst))
                   || (req_chunk_out && (out_cnt == OutFull))
                   || (out_vector_valid && (out_cnt != OutLast) && !req_chunk_out);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)       proto_err <= 1'b0;
        else if (err_now) proto_err <= 1'b1;
    end
`else
    logic unused_ovv;
    assign unused_ovv = out_vector_valid;
`endif

endmodule

// File: tb/tb_vec_chunk_server.sv
// Directed bench for vec_chunk_server: fill, chunk serving, rewind, drain with scoreboard, async reset.
// Exercises proto_err when VCB_PROTOCOL_CHECK_EN is defined.
module tb_vec_chunk_server;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic               wr_valid;
    logic signed [7:0]  wr_data;
    logic               wr_ready;
    logic               in_data_ready;
    logic signed [31:0] in_data;
    logic               req_chunk_in;
    logic               req_chunk_ptr_rst;
    logic               req_chunk_out;
    logic signed [7:0]  write_out_data;
    logic               out_vector_valid;
    logic               out_valid;
    logic signed [7:0]  out_data;
    logic               out_ready;
`ifdef VCB_PROTOCOL_CHECK_EN
    logic               proto_err;
`endif

    int n_pass  = 0;
    int n_total = 0;
    logic [7:0] exp_q[$];

    vec_chunk_server #(
        .InVecLength (8),
        .OutVecLength(4),
        .WorkingRegs (4)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .wr_valid         (wr_valid),
        .wr_data          (wr_data),
        .wr_ready         (wr_ready),
        .in_data_ready    (in_data_ready),
        .in_data          (in_data),
        .req_chunk_in     (req_chunk_in),
        .req_chunk_ptr_rst(req_chunk_ptr_rst),
        .req_chunk_out    (req_chunk_out),
        .write_out_data   (write_out_data),
        .out_vector_valid (out_vector_valid),
`ifdef VCB_PROTOCOL_CHECK_EN
        .proto_err        (proto_err),
`endif
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_ready        (out_ready)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic fill(input logic [7:0] base);
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1;
            wr_data  = base + 8'(i);
            tick();
        end
    endtask

    task automatic pulse_in();
        req_chunk_in = 1'b1;
        tick();
        req_chunk_in = 1'b0;
    endtask

    initial begin
        int   got;
        int   guard;
        logic stalled;

        rst_in            = 1'b1;
        wr_valid          = 1'b0;
        wr_data           = '0;
        req_chunk_in      = 1'b0;
        req_chunk_ptr_rst = 1'b0;
        req_chunk_out     = 1'b0;
        write_out_data    = '0;
        out_vector_valid  = 1'b0;
        out_ready         = 1'b0;
        #3;
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("rst_in_data_ready", {31'd0, in_data_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_in_data", in_data, 32'd0);
`ifdef VCB_PROTOCOL_CHECK_EN
        chk("rst_proto_err", {31'd0, proto_err}, 32'd0);
`endif
        @(negedge clk_in);
        rst_in = 1'b0;
        tick();

        // Fill with 1..8, wr_valid held high past the last byte
        chk("fill_ready_pre", {31'd0, wr_ready}, 32'd1);
        fill(8'd1);
        chk("fill_ready_post", {31'd0, wr_ready}, 32'd0);
        chk("fill_idr", {31'd0, in_data_ready}, 32'd1);
        chk("fill_chunk0", in_data, 32'h04030201);
        wr_data = 8'd99;
        tick();
        wr_valid = 1'b0;
        chk("fill_ignored", in_data, 32'h04030201);
        chk("serve_idr_hold", {31'd0, in_data_ready}, 32'd1);

        // Advance and wrap
        pulse_in();
        chk("adv_chunk1", in_data, 32'h08070605);
        chk("adv_idr_low", {31'd0, in_data_ready}, 32'd0);
        pulse_in();
        chk("adv_wrap0", in_data, 32'h04030201);
        pulse_in();
        chk("adv_chunk1b", in_data, 32'h08070605);

        // Rewind has priority over advance
        req_chunk_in      = 1'b1;
        req_chunk_ptr_rst = 1'b1;
        tick();
        chk("rew_from1", in_data, 32'h04030201);
        tick();
        req_chunk_in      = 1'b0;
        req_chunk_ptr_rst = 1'b0;
        chk("rew_from0", in_data, 32'h04030201);
        chk("serve_no_out", {31'd0, out_valid}, 32'd0);

        // Collect results; scoreboard holds the expected drain order
        out_ready     = 1'b1;
        req_chunk_out = 1'b1;
        write_out_data = 8'sd10;  exp_q.push_back(8'd10);  tick();
        write_out_data = -8'sd3;  exp_q.push_back(8'hFD);  tick();
        write_out_data = 8'sd7;   exp_q.push_back(8'd7);   tick();
        write_out_data = 8'sd127; exp_q.push_back(8'd127); tick();
        req_chunk_out = 1'b0;
        chk("drain_wr_ready", {31'd0, wr_ready}, 32'd0);

        got     = 0;
        guard   = 0;
        stalled = 1'b0;
        while (got < 4 && guard < 40) begin
            if (got > 0) chk("drain_gap", {31'd0, out_valid}, 32'd1);
            if (out_valid) begin
                if (got == 2 && !stalled) begin
                    out_ready = 1'b0;
                    for (int s = 0; s < 5; s++) begin
                        tick();
                        chk("stall_valid", {31'd0, out_valid}, 32'd1);
                        chk("stall_data", {24'd0, out_data}, {24'd0, exp_q[0]});
                    end
                    out_ready = 1'b1;
                    stalled   = 1'b1;
                end
                chk("drain_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
                got++;
            end
            tick();
            guard++;
        end
        chk("drain_count", got, 32'd4);
        chk("drain_q_empty", exp_q.size(), 32'd0);
        chk("post_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_wr_ready", {31'd0, wr_ready}, 32'd1);

        // Second vector, then async reset mid-SERVE
        fill(8'h11);
        wr_valid = 1'b0;
        chk("fill2_chunk0", in_data, 32'h14131211);
        pulse_in();
        chk("fill2_chunk1", in_data, 32'h18171615);
        #2;
        rst_in = 1'b1;
        #1;
        chk("arst_wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("arst_idr", {31'd0, in_data_ready}, 32'd0);
        chk("arst_in_data", in_data, 32'd0);
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        tick();

        // Request during FILL is ignored (and flagged when checking is enabled)
        pulse_in();
`ifdef VCB_PROTOCOL_CHECK_EN
        chk("proto_err_set", {31'd0, proto_err}, 32'd1);
`endif
        chk("refill_idr_pre", {31'd0, in_data_ready}, 32'd0);
        fill(8'hA0);
        wr_valid = 1'b0;
        chk("refill_idr", {31'd0, in_data_ready}, 32'd1);
        chk("refill_chunk0", in_data, 32'hA3A2A1A0);
        pulse_in();
        chk("refill_chunk1", in_data, 32'hA7A6A5A4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
